// File: rtl/minim_pkg.sv
// Shared field codes, FSM state type and base-3 helper for the prime-implicant streamer.
package minim_pkg;

  localparam logic [1:0] LIT_NEG = 2'b00;
  localparam logic [1:0] LIT_POS = 2'b01;
  localparam logic [1:0] LIT_DC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_END
  } state_e;

  function automatic int unsigned pow3(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 3;
    end
    return r;
  endfunction

endpackage

// File: rtl/cube_cover_check.sv
// Combinational cube test: does the cube lie inside on|dc, and does it touch a pure on-minterm.
module cube_cover_check
  import minim_pkg::*;
#(
  parameter int unsigned N_VARS = 5,
  parameter int unsigned CAP_W  = $clog2(N_VARS + 1)
) (
  input  logic [2*N_VARS-1:0]    cube,
  input  logic [0:2**N_VARS-1]   on_set,
  input  logic [0:2**N_VARS-1]   dc_set,
  input  logic [CAP_W-1:0]       k,
  output logic                   implicant,
  output logic                   covers_on
);

  logic [N_VARS-1:0] act;
  logic [N_VARS-1:0] fixed;
  logic [N_VARS-1:0] want;
  logic [N_VARS-1:0] mv;
  logic              hit;

  for (genvar i = 0; i < N_VARS; i++) begin : g_field
    assign act[i]   = (CAP_W'(i) < k);
    assign fixed[i] = act[i] && (cube[2*i +: 2] != LIT_DC);
    assign want[i]  = cube[2*i];
  end

  // Minterms with a set bit above k lie outside the active table and are never covered.
  always_comb begin
    implicant = 1'b1;
    covers_on = 1'b0;
    mv        = '0;
    hit       = 1'b0;
    for (int unsigned m = 0; m < 2**N_VARS; m++) begin
      mv  = N_VARS'(m);
      hit = (((mv ^ want) & fixed) == '0) && ((mv & ~act) == '0);
      if (hit) begin
        if (!on_set[mv] && !dc_set[mv]) implicant = 1'b0;
        if (on_set[mv] && !dc_set[mv])  covers_on = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minim_prime_stream.sv
// Streams every prime implicant of a captured truth table, one cube evaluated per clock.
// Optional feature macro: MINIM_DC_EN adds the dc_mask don't-care input.
module minim_prime_stream
  import minim_pkg::*;
#(
  parameter int unsigned N_VARS = 5,
  parameter int unsigned CAP_W  = $clog2(N_VARS + 1),
  parameter int unsigned RES_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_ready,
  input  logic [0:2**N_VARS-1]   data,
  input  logic [CAP_W-1:0]       capacity,
`ifdef MINIM_DC_EN
  input  logic [0:2**N_VARS-1]   dc_mask,
`endif
  input  logic                   res_ready,
  output logic                   ready_result,
  output logic [2*N_VARS-1:0]    result,
  output logic                   result_end,
  output logic [RES_W-1:0]       res_count,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [0:2**N_VARS-1]   data_q, data_d;
  logic [0:2**N_VARS-1]   dc_set;
  logic [CAP_W-1:0]       cap_q, cap_d;
  logic [2*N_VARS-1:0]    cube_q, cube_d;
  logic [2*N_VARS-1:0]    result_q, result_d;
  logic                   rr_q, rr_d;
  logic [RES_W-1:0]       count_q, count_d;

`ifdef MINIM_DC_EN
  logic [0:2**N_VARS-1]   dc_q, dc_d;
  assign dc_set = dc_q;
`else
  assign dc_set = '0;
`endif

  logic [N_VARS-1:0]      act;
  logic [N_VARS:0]        impl_v, cov_v, carry;
  logic [N_VARS-1:0]      block;
  logic [2*N_VARS-1:0]    cube_inc;
  logic                   prime, last_cube, slot_free, cap_ok;

  // Instance e < N_VARS checks the cube with field e widened to don't-care; instance N_VARS checks the cube itself.
  for (genvar e = 0; e <= N_VARS; e++) begin : g_chk
    logic [2*N_VARS-1:0] c;
    if (e < N_VARS) begin : g_exp
      always_comb begin
        c            = cube_q;
        c[2*e +: 2]  = LIT_DC;
      end
    end else begin : g_self
      assign c = cube_q;
    end
    cube_cover_check #(.N_VARS(N_VARS), .CAP_W(CAP_W)) u_chk (
      .cube      (c),
      .on_set    (data_q),
      .dc_set    (dc_set),
      .k         (cap_q),
      .implicant (impl_v[e]),
      .covers_on (cov_v[e])
    );
  end

  // Base-3 ripple increment; inactive fields stay 00 and just pass the carry.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < N_VARS; i++) begin : g_inc
    logic [1:0] f;
    assign f      = cube_q[2*i +: 2];
    assign act[i] = (CAP_W'(i) < cap_q);
    assign cube_inc[2*i +: 2] = (act[i] && carry[i]) ? ((f == LIT_DC) ? LIT_NEG : f + 2'b01) : f;
    assign carry[i+1] = carry[i] && (!act[i] || (f == LIT_DC));
    assign block[i]   = act[i] && (f != LIT_DC) && impl_v[i];
  end

  // Every expansion is a superset of the cube, so the AND equals the cube's own covers_on.
  assign prime     = impl_v[N_VARS] && (&cov_v) && (block == '0);
  assign last_cube = carry[N_VARS];
  assign slot_free = !rr_q || res_ready;
  assign cap_ok    = (capacity != '0) && (capacity <= CAP_W'(N_VARS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      cap_q    <= '0;
      cube_q   <= '0;
      result_q <= '0;
      rr_q     <= 1'b0;
      count_q  <= '0;
`ifdef MINIM_DC_EN
      dc_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cap_q    <= cap_d;
      cube_q   <= cube_d;
      result_q <= result_d;
      rr_q     <= rr_d;
      count_q  <= count_d;
`ifdef MINIM_DC_EN
      dc_q     <= dc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (data_ready) state_d = cap_ok ? ST_SCAN : ST_END;
      ST_SCAN:  if (slot_free && last_cube) state_d = ST_DRAIN;
      ST_DRAIN: if (slot_free) state_d = ST_END;
      ST_END:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    cap_d    = cap_q;
    cube_d   = cube_q;
    result_d = result_q;
    rr_d     = rr_q;
    count_d  = count_q;
`ifdef MINIM_DC_EN
    dc_d     = dc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (data_ready) begin
          data_d  = data;
          cap_d   = capacity;
          cube_d  = '0;
          count_d = '0;
`ifdef MINIM_DC_EN
          dc_d    = dc_mask;
`endif
        end
      end
      ST_SCAN: begin
        if (slot_free) begin
          cube_d = cube_inc;
          if (prime) begin
            result_d = cube_q;
            rr_d     = 1'b1;
            count_d  = count_q + RES_W'(1);
          end else begin
            rr_d = 1'b0;
          end
        end
      end
      ST_DRAIN: if (slot_free) rr_d = 1'b0;
      ST_END:   rr_d = 1'b0;
      default:  rr_d = 1'b0;
    endcase
    busy       = (state_q != ST_IDLE);
    result_end = (state_q == ST_END);
  end

  assign ready_result = rr_q;
  assign result       = result_q;
  assign res_count    = count_q;

endmodule

// File: doc/minim_prime_stream.md
# minim_prime_stream

Parametrised successor to the fixed five-variable minimiser FSM. It captures a truth table of up to `N_VARS` variables and scans every cube in base-3 order, one cube per clock. It emits each prime implicant as a 2-bit-per-variable cube word on a valid/ready stream, then signals end-of-run. It sits between the truth-table loader and the cover-selection stage.

## Interface
- `N_VARS`, default 5: maximum number of variables. Truth table is `2**N_VARS` bits wide.
- `CAP_W`, default `$clog2(N_VARS+1)`: width of `capacity`.
- `RES_W`, default 8: width of `res_count`. Must hold `3**N_VARS`.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_ready`  in  1  start request; sampled only in IDLE.
- `data`  in  `[0:2**N_VARS-1]`  truth table; `data[m]` = f(minterm m); variable i = bit i of m.
- `capacity`  in  CAP_W  active variable count k.
- `dc_mask`  in  `[0:2**N_VARS-1]`  don't-care minterms. Present only with `MINIM_DC_EN`.
- `res_ready`  in  1  downstream accepts `result`.
- `ready_result`  out  1  `result` valid.
- `result`  out  `2*N_VARS`  prime cube. Field i = bits `[2i+1:2i]`. Encoding: 00 = xi'; 01 = xi; 10 = don't-care; 11 unused. Fields i ≥ k are 00.
- `result_end`  out  1  one-cycle pulse at end of run.
- `res_count`  out  RES_W  primes emitted in the current or last run.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, SCAN, DRAIN, END.
- **IDLE**
  - When `data_ready`=1, register `data`, `capacity` (and `dc_mask` when compiled in).
  - Clear `res_count` and the cube counter, then go to SCAN.
  - `data_ready` is ignored outside IDLE.
- **Cube counter**
  - k base-3 digits; digit i maps 0/1/2 to field codes 00/01/10.
  - Digit 0 is least significant, so scan order is fixed and cube index = Σ dᵢ·3ⁱ.
- **SCAN**: evaluates the current cube combinationally.
  - A cube is an *implicant* if every covered minterm is in on∪dc.
  - A cube is *prime* if it is an implicant, covers at least one on-minterm, and replacing any single fixed field with 10 is not an implicant.
- **Advance rule**: the counter advances only when the output slot is free, i.e. `ready_result`=0 or `res_ready`=1.
  - On advance, a prime cube loads `result`, sets `ready_result` and increments `res_count`.
  - On advance, a non-prime cube loads nothing; `ready_result` clears if the old word was accepted.
- **Last cube** (index `3**k-1`) advanced: go to DRAIN.
- **DRAIN**: wait until `ready_result`=0 or `res_ready`=1, then go to END.
- **END**: `result_end`=1 for one cycle, clear `ready_result`, go to IDLE. `res_count` holds until the next start.
- **Out-of-range capacity** (`capacity`=0 or `capacity`>`N_VARS`): skip SCAN and go straight to END. No results; `res_count`=0.
- **Output stability**: while `ready_result`=1 and `res_ready`=0, `result` holds stable.
- **Mid-run reset**: `rst` in any state aborts the run and gives the reset values below on the next edge.

## Timing
- Reset values: `ready_result`=0, `result`=0, `result_end`=0, `res_count`=0, `busy`=0; state IDLE.
- Start at edge T (IDLE, `data_ready`=1): `busy`=1 from T+1; cube 0 is evaluated in cycle T+1.
- A prime cube evaluated in cycle C is visible on `result` from C+1.
- Throughput: 1 cube/cycle with `res_ready` held high.
- `result_end` asserts exactly 1 cycle after DRAIN exits. With no stalls, this is `3**k`+2 cycles after the start edge.
- A word counts as transferred on any edge with `ready_result`=1 and `res_ready`=1.

## Configuration
- `MINIM_DC_EN` defined:
  - `dc_mask` port exists and is registered at start.
  - dc minterms count toward implicant coverage, but never satisfy the "covers an on-minterm" rule.
  - A minterm flagged in both `data` and `dc_mask` is treated as dc.
- `MINIM_DC_EN` undefined:
  - No `dc_mask` port; the dc set is empty.
  - The prime test uses `data` only.

## Structure
- Package `minim_pkg` holds:
  - field codes `LIT_NEG`=2'b00, `LIT_POS`=2'b01, `LIT_DC`=2'b10;
  - FSM state enum;
  - `pow3` constant function.
- Sub-module `cube_cover_check`: combinational; (cube, on, dc, k) → implicant, covers_on.
  - Instantiated `N_VARS+1` times: one for the cube itself, one per single-field expansion.

## Test plan
All scenarios use `N_VARS`=5.
- k=3, `data[0:7]`=all 1 → exactly one result `10'b0000101010`, `res_count`=1, then `result_end` pulse.
- k=2, `data[1]`=`data[2]`=1 (XOR), others 0 → results `10'h001` then `10'h004` in that order, `res_count`=2.
- k=5, `data`=0 → `ready_result` never asserts; `result_end` at start+245 cycles; `res_count`=0.
- XOR case with `res_ready` low for 10 cycles after the first valid → `10'h001` held stable, no loss or duplicate, final `res_count`=2.
- `rst` pulse mid-SCAN with k=5, `data`=`32'hBFBFF6FF` → all outputs 0 and `busy`=0 next cycle; a new start afterwards completes normally.
- With `MINIM_DC_EN`: k=2, `data[1]`=1, `dc_mask[3]`=1 → single result `10'b0000001001`, `res_count`=1.
